// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and helpers for the unified-RAM port arbiter.
// Build option (see mem_port_arbiter): ARB_RR_EN.
package mem_arb_pkg;

  // Arbiter FSM: idle/grant cycle, then wait for the RAM response
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Owner / last-granted port encoding
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  // Number of byte strobes for a given data width
  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner select between fetch and load/store requests.
// Build option: ARB_RR_EN selects round-robin tie-break on i_last; otherwise dm > if.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_if_req,
  input  logic i_dm_req,
`ifdef ARB_RR_EN
  input  logic i_last,
`endif
  output logic o_any_req,
  output logic o_winner
);

  // Pick the winning port; a lone requester always wins
  always_comb begin
    o_any_req = i_if_req | i_dm_req;
    o_winner  = OWN_IF;
`ifdef ARB_RR_EN
    if (i_if_req && i_dm_req) begin
      o_winner = (i_last == OWN_IF) ? OWN_DM : OWN_IF;
    end else if (i_dm_req) begin
      o_winner = OWN_DM;
    end
`else
    if (i_dm_req) begin
      o_winner = OWN_DM;
    end
`endif
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-port unified RAM between instruction fetch (if_*)
// and load/store (dm_*). One transaction in flight: grant+launch in IDLE, rvalid
// MEM_LAT cycles later. Build option: ARB_RR_EN (round-robin tie-break, adds r_last).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      if_req,
  input  logic [ADDR_W-1:0]         if_addr,
  output logic                      if_gnt,
  output logic                      if_rvalid,
  output logic [DATA_W-1:0]         if_rdata,
  input  logic                      dm_req,
  input  logic                      dm_we,
  input  logic [strb_w(DATA_W)-1:0] dm_wstrb,
  input  logic [ADDR_W-1:0]         dm_addr,
  input  logic [DATA_W-1:0]         dm_wdata,
  output logic                      dm_gnt,
  output logic                      dm_rvalid,
  output logic [DATA_W-1:0]         dm_rdata,
  output logic                      mem_en,
  output logic [strb_w(DATA_W)-1:0] mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);

  // Counter holds up to MEM_LAT-1 = 3
  localparam int                CNT_W    = 2;
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(MEM_LAT - 1);

  state_t              r_state, w_state_next;
  logic [CNT_W-1:0]    r_cnt, w_cnt_next;
  logic                r_owner, w_owner_next;
  logic                r_store, w_store_next;
  logic [DATA_W-1:0]   r_if_rdata, w_if_rdata_next;
  logic [DATA_W-1:0]   r_dm_rdata, w_dm_rdata_next;
  logic [DATA_W-1:0]   w_dm_resp;
  logic                w_any_req;
  logic                w_winner;
`ifdef ARB_RR_EN
  logic                r_last;
`endif

  mem_arb_pick u_pick (
    .i_if_req  (if_req),
    .i_dm_req  (dm_req),
`ifdef ARB_RR_EN
    .i_last    (r_last),
`endif
    .o_any_req (w_any_req),
    .o_winner  (w_winner)
  );

  // Store completions return zero; loads return the RAM word
  assign w_dm_resp = r_store ? '0 : mem_rdata;

  // State, counter, ownership and held response data
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_owner    <= OWN_IF;
      r_store    <= 1'b0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_owner    <= w_owner_next;
      r_store    <= w_store_next;
      r_if_rdata <= w_if_rdata_next;
      r_dm_rdata <= w_dm_rdata_next;
    end
  end

`ifdef ARB_RR_EN
  // Remember the most recently granted port for the next tie
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_last <= OWN_IF;
    end else if (if_gnt || dm_gnt) begin
      r_last <= dm_gnt ? OWN_DM : OWN_IF;
    end
  end
`endif

  // Next-state logic, grant/launch in IDLE, response pulse at the end of WAIT.
  // Outputs are gated by resetn so nothing is granted while reset is held.
  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_owner_next    = r_owner;
    w_store_next    = r_store;
    w_if_rdata_next = r_if_rdata;
    w_dm_rdata_next = r_dm_rdata;
    if_gnt          = 1'b0;
    dm_gnt          = 1'b0;
    if_rvalid       = 1'b0;
    dm_rvalid       = 1'b0;
    if_rdata        = r_if_rdata;
    dm_rdata        = r_dm_rdata;
    mem_en          = 1'b0;
    mem_we          = '0;
    mem_addr        = if_addr;
    mem_wdata       = '0;
    if (resetn) begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            mem_en       = 1'b1;
            w_owner_next = w_winner;
            w_cnt_next   = CNT_INIT;
            w_state_next = ST_WAIT;
            if (w_winner == OWN_DM) begin
              dm_gnt       = 1'b1;
              mem_addr     = dm_addr;
              mem_wdata    = dm_wdata;
              mem_we       = dm_we ? dm_wstrb : '0;
              w_store_next = dm_we;
            end else begin
              if_gnt       = 1'b1;
              w_store_next = 1'b0;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            w_state_next = ST_IDLE;
            if (r_owner == OWN_DM) begin
              dm_rvalid       = 1'b1;
              dm_rdata        = w_dm_resp;
              w_dm_rdata_next = w_dm_resp;
            end else begin
              if_rvalid       = 1'b1;
              if_rdata        = mem_rdata;
              w_if_rdata_next = mem_rdata;
            end
          end else begin
            w_cnt_next = r_cnt - 1'b1;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: four arbiter lanes with MEM_LAT = 1..4, each with its own RAM model
// (word[addr] = addr ^ 32'hA5A5_0000) and a per-lane scoreboard monitor.
// Honors ARB_RR_EN for the contention expectations.
module tb_mem_port_arbiter;

  logic clk;
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;

  logic        resetn_v [4];
  logic        if_req_v [4];
  logic        if_gnt_v [4];
  logic        if_rvalid_v [4];
  logic        dm_req_v [4];
  logic        dm_we_v [4];
  logic        dm_gnt_v [4];
  logic        dm_rvalid_v [4];
  logic        mem_en_v [4];
  logic [31:0] if_addr_v [4];
  logic [31:0] if_rdata_v [4];
  logic [31:0] dm_addr_v [4];
  logic [31:0] dm_wdata_v [4];
  logic [31:0] dm_rdata_v [4];
  logic [31:0] mem_addr_v [4];
  logic [31:0] mem_wdata_v [4];
  logic [31:0] mem_rdata_v [4];
  logic [3:0]  dm_wstrb_v [4];
  logic [3:0]  mem_we_v [4];

  typedef struct {
    bit          port;   // 1 = dm
    logic [31:0] data;
    int          due;
  } exp_t;

  typedef struct {
    logic        is_dm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [3:0]  exp_we;
    logic [31:0] exp_rdata;
  } vec_t;

`ifdef ARB_RR_EN
  localparam logic [5:0] CONT_DM = 6'b010001;
  localparam logic [5:0] CONT_IF = 6'b000100;
`else
  localparam logic [5:0] CONT_DM = 6'b010101;
  localparam logic [5:0] CONT_IF = 6'b000000;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input int lane,
                                input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s lane%0d: got 0x%0h, required 0x%0h", name, lane, act, exp);
  endfunction

  function automatic void fail_ev(input string name, input int lane, input int budget);
    n_total++;
    $display("FAIL %s lane%0d: got no event within %0d cycles, required one", name, lane, budget);
  endfunction

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam int LAT = gi + 1;
    logic [31:0] ram [256];
    logic [31:0] pipe [4];
    exp_t        q [$];
    exp_t        e;
    logic        g_if, g_dm;
    logic [31:0] last_if = '0;
    logic [31:0] last_dm = '0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
      .clk       (clk),
      .resetn    (resetn_v[gi]),
      .if_req    (if_req_v[gi]),
      .if_addr   (if_addr_v[gi]),
      .if_gnt    (if_gnt_v[gi]),
      .if_rvalid (if_rvalid_v[gi]),
      .if_rdata  (if_rdata_v[gi]),
      .dm_req    (dm_req_v[gi]),
      .dm_we     (dm_we_v[gi]),
      .dm_wstrb  (dm_wstrb_v[gi]),
      .dm_addr   (dm_addr_v[gi]),
      .dm_wdata  (dm_wdata_v[gi]),
      .dm_gnt    (dm_gnt_v[gi]),
      .dm_rvalid (dm_rvalid_v[gi]),
      .dm_rdata  (dm_rdata_v[gi]),
      .mem_en    (mem_en_v[gi]),
      .mem_we    (mem_we_v[gi]),
      .mem_addr  (mem_addr_v[gi]),
      .mem_wdata (mem_wdata_v[gi]),
      .mem_rdata (mem_rdata_v[gi])
    );

    initial for (int i = 0; i < 256; i++) ram[i] = 32'(i * 4) ^ 32'hA5A5_0000;

    // RAM model: read-first, data appears LAT cycles after mem_en
    always @(posedge clk) begin
      if (mem_en_v[gi]) begin
        pipe[0] <= ram[mem_addr_v[gi][9:2]];
        for (int b = 0; b < 4; b++)
          if (mem_we_v[gi][b]) ram[mem_addr_v[gi][9:2]][b*8 +: 8] <= mem_wdata_v[gi][b*8 +: 8];
      end
      for (int j = 1; j < 4; j++) pipe[j] <= pipe[j-1];
    end
    assign mem_rdata_v[gi] = pipe[LAT-1];

    // Scoreboard monitor: push on grant, pop and compare on rvalid
    always @(negedge clk) begin
      if (!resetn_v[gi]) begin
        q.delete();
        last_if = '0;
        last_dm = '0;
        check("reset ctl", gi, {23'd0, if_gnt_v[gi], dm_gnt_v[gi], mem_en_v[gi], mem_we_v[gi],
                                if_rvalid_v[gi], dm_rvalid_v[gi]}, 32'd0);
        check("reset if_rdata", gi, if_rdata_v[gi], 32'd0);
        check("reset dm_rdata", gi, dm_rdata_v[gi], 32'd0);
      end else begin
        g_if = if_gnt_v[gi];
        g_dm = dm_gnt_v[gi];
        check("mem_en vs gnt", gi, {31'd0, mem_en_v[gi]}, {31'd0, g_if | g_dm});
        if (g_if || g_dm) begin
          check("single grant", gi, {31'd0, g_if & g_dm}, 32'd0);
          check("grant while busy", gi, q.size(), 32'd0);
          e.port = g_dm;
          e.due  = cyc + LAT;
          if (g_dm) begin
            check("dm mem_addr", gi, mem_addr_v[gi], dm_addr_v[gi]);
            check("dm mem_we", gi, {28'd0, mem_we_v[gi]}, dm_we_v[gi] ? {28'd0, dm_wstrb_v[gi]} : 32'd0);
            if (dm_we_v[gi]) check("dm mem_wdata", gi, mem_wdata_v[gi], dm_wdata_v[gi]);
            e.data = dm_we_v[gi] ? 32'd0 : ram[dm_addr_v[gi][9:2]];
          end else begin
            check("if mem_addr", gi, mem_addr_v[gi], if_addr_v[gi]);
            check("if mem_we", gi, {28'd0, mem_we_v[gi]}, 32'd0);
            e.data = ram[if_addr_v[gi][9:2]];
          end
          q.push_back(e);
        end
        if (if_rvalid_v[gi] || dm_rvalid_v[gi]) begin
          if (q.size() == 0) begin
            check("spurious rvalid", gi, {30'd0, if_rvalid_v[gi], dm_rvalid_v[gi]}, 32'd0);
          end else begin
            e = q.pop_front();
            check("rvalid port", gi, {30'd0, if_rvalid_v[gi], dm_rvalid_v[gi]}, e.port ? 32'd1 : 32'd2);
            check("rdata", gi, e.port ? dm_rdata_v[gi] : if_rdata_v[gi], e.data);
            check("latency", gi, cyc, e.due);
            if (e.port) last_dm = e.data;
            else        last_if = e.data;
            $display("lane%0d %s response @%0d data=0x%08h", gi, e.port ? "dm" : "if", cyc,
                     e.port ? dm_rdata_v[gi] : if_rdata_v[gi]);
          end
        end else if (q.size() != 0 && cyc >= q[0].due) begin
          fail_ev("missing rvalid", gi, LAT);
          void'(q.pop_front());
        end
        if (!if_rvalid_v[gi]) check("if_rdata hold", gi, if_rdata_v[gi], last_if);
        if (!dm_rvalid_v[gi]) check("dm_rdata hold", gi, dm_rdata_v[gi], last_dm);
      end
    end
  end

  task automatic drive_req(input int k, input logic is_dm, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb);
    if (is_dm) begin
      dm_req_v[k] = 1'b1; dm_we_v[k] = we; dm_addr_v[k] = addr;
      dm_wdata_v[k] = wdata; dm_wstrb_v[k] = strb;
    end else begin
      if_req_v[k] = 1'b1; if_addr_v[k] = addr;
    end
  endtask

  task automatic wait_gnt(input int k, input logic is_dm, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = is_dm ? dm_gnt_v[k] : if_gnt_v[k];
    end
    if (!ok) fail_ev("gnt timeout", k, 20);
  endtask

  task automatic wait_rvalid(input int k, input logic is_dm, input int budget,
                             output int lat, output logic [31:0] data, output bit ok);
    ok = 1'b0; lat = 0; data = '0;
    for (int i = 1; i <= budget && !ok; i++) begin
      @(negedge clk);
      if (is_dm ? dm_rvalid_v[k] : if_rvalid_v[k]) begin
        ok = 1'b1; lat = i; data = is_dm ? dm_rdata_v[k] : if_rdata_v[k];
      end
    end
    if (!ok) fail_ev("rvalid timeout", k, budget);
  endtask

  task automatic rand_traffic(input int k, input int ncyc);
    logic gi_s, gd_s;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      gi_s = if_gnt_v[k];
      gd_s = dm_gnt_v[k];
      @(posedge clk); #1;
      if (!if_req_v[k] || gi_s) begin
        if_req_v[k]  = ($urandom_range(0, 2) != 0);
        if_addr_v[k] = {22'd0, 8'($urandom_range(0, 63)), 2'b00};
      end else if ($urandom_range(0, 15) == 0) begin
        if_req_v[k] = 1'b0;
      end
      if (!dm_req_v[k] || gd_s) begin
        dm_req_v[k]   = ($urandom_range(0, 2) != 0);
        dm_we_v[k]    = 1'($urandom_range(0, 1));
        dm_addr_v[k]  = {22'd0, 8'($urandom_range(0, 63)), 2'b00};
        dm_wdata_v[k] = $urandom;
        dm_wstrb_v[k] = 4'($urandom_range(0, 15));
      end else if ($urandom_range(0, 15) == 0) begin
        dm_req_v[k] = 1'b0;
      end
    end
    if_req_v[k] = 1'b0;
    dm_req_v[k] = 1'b0;
  endtask

  vec_t        vecs [9];
  bit          ok;
  int          lat;
  logic [31:0] rd;
  logic [5:0]  exp_dm, exp_if;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0,         4'h0, 4'h0, 32'hA5A5_0010};
    vecs[1] = '{1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF, 4'h3, 4'h3, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h20, 32'h0,         4'h0, 4'h0, 32'hA5A5_BEEF};
    vecs[3] = '{1'b0, 1'b0, 32'h20, 32'h0,         4'h0, 4'h0, 32'hA5A5_BEEF};
    vecs[4] = '{1'b1, 1'b1, 32'h30, 32'h1234_5678, 4'hF, 4'hF, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 32'h30, 32'h0,         4'h0, 4'h0, 32'h1234_5678};
    vecs[6] = '{1'b1, 1'b1, 32'h30, 32'hAABB_CCDD, 4'h8, 4'h8, 32'h0};
    vecs[7] = '{1'b1, 1'b0, 32'h30, 32'h0,         4'h0, 4'h0, 32'hAA34_5678};
    vecs[8] = '{1'b1, 1'b0, 32'h44, 32'hFFFF_FFFF, 4'hF, 4'h0, 32'hA5A5_0044};
    exp_dm = CONT_DM;
    exp_if = CONT_IF;

    // Reset held 5 cycles with both requests high on every lane
    for (int k = 0; k < 4; k++) begin
      resetn_v[k] = 1'b0; if_req_v[k] = 1'b1; dm_req_v[k] = 1'b1; dm_we_v[k] = 1'b0;
      if_addr_v[k] = 32'h0; dm_addr_v[k] = 32'h4; dm_wdata_v[k] = 32'h0; dm_wstrb_v[k] = 4'h0;
    end
    repeat (5) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      resetn_v[k] = 1'b1; if_req_v[k] = 1'b0; dm_req_v[k] = 1'b0;
    end

    // Table-driven single transactions on the MEM_LAT=1 lane
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      drive_req(0, vecs[i].is_dm, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].strb);
      wait_gnt(0, vecs[i].is_dm, ok);
      if (ok) begin
        check($sformatf("vec%0d mem_en", i), 0, {31'd0, mem_en_v[0]}, 32'd1);
        check($sformatf("vec%0d mem_we", i), 0, {28'd0, mem_we_v[0]}, {28'd0, vecs[i].exp_we});
      end
      @(posedge clk); #1;
      if_req_v[0] = 1'b0; dm_req_v[0] = 1'b0;
      wait_rvalid(0, vecs[i].is_dm, 6, lat, rd, ok);
      if (ok) begin
        check($sformatf("vec%0d rdata", i), 0, rd, vecs[i].exp_rdata);
        check($sformatf("vec%0d latency", i), 0, lat, 32'd1);
      end
    end

    // Contention: both requests held 6 cycles right after a reset
    @(posedge clk); #1; resetn_v[0] = 1'b0;
    @(posedge clk); #1; resetn_v[0] = 1'b1;
    drive_req(0, 1'b0, 1'b0, 32'h50, 32'h0, 4'h0);
    drive_req(0, 1'b1, 1'b0, 32'h60, 32'h0, 4'h0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("contend dm_gnt c%0d", c), 0, {31'd0, dm_gnt_v[0]}, {31'd0, exp_dm[c]});
      check($sformatf("contend if_gnt c%0d", c), 0, {31'd0, if_gnt_v[0]}, {31'd0, exp_if[c]});
    end
    @(posedge clk); #1;
    if_req_v[0] = 1'b0; dm_req_v[0] = 1'b0;
    repeat (3) @(posedge clk);

    // Abort: MEM_LAT=3 lane, reset pulsed one cycle after a fetch grant
    #1; drive_req(2, 1'b0, 1'b0, 32'h14, 32'h0, 4'h0);
    wait_gnt(2, 1'b0, ok);
    @(posedge clk); #1; if_req_v[2] = 1'b0; resetn_v[2] = 1'b0;
    @(posedge clk); #1; resetn_v[2] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("abort no if_rvalid", 2, {31'd0, if_rvalid_v[2]}, 32'd0);
    end
    @(posedge clk); #1; drive_req(2, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    @(negedge clk);
    check("abort next gnt", 2, {31'd0, dm_gnt_v[2]}, 32'd1);
    @(posedge clk); #1; dm_req_v[2] = 1'b0;
    wait_rvalid(2, 1'b1, 8, lat, rd, ok);
    if (ok) begin
      check("abort next rdata", 2, rd, 32'hA5A5_0010);
      check("abort next latency", 2, lat, 32'd3);
    end

    // Random mixed traffic on all four latencies, checked by the lane scoreboards
    @(posedge clk); #1;
    fork
      rand_traffic(0, 300);
      rand_traffic(1, 300);
      rand_traffic(2, 300);
      rand_traffic(3, 300);
    join
    repeat (10) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
